// File: rtl/morse_decoder.sv
// Morse key decoder: times key presses and gaps in divided-clock ticks,
// classifies dots/dashes, and emits one ASCII character per letter gap.
module morse_decoder #(
  parameter int TICK_DIV   = 1000000,
  parameter int DASH_UNITS = 2,
  parameter int GAP_UNITS  = 3,
  parameter int CNT_W      = 8
) (
  input  logic       CLOCK,
  input  logic       reset_n,
  input  logic       KEY,
  output logic [7:0] ASCII,
  output logic       CHAR_VALID,
  output logic       ERR,
  output logic [2:0] SYM_LEN,
  output logic       BUSY
);

  // state | meaning
  // IDLE  | no character in progress, waiting for a press
  // MARK  | key held, counting press ticks
  // SPACE | key released after a symbol, counting gap ticks
  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_UNITS);

  state_t             state;
  logic               key_meta, ks, ks_d;
  logic               rise_q, fall_q;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [CNT_W-1:0]   press_cnt, gap_cnt;
  logic [4:0]         sym_buf;
  logic [2:0]         sym_len;
  logic               ovf;
  logic               pending;
  logic [7:0]         lut_char;

  // Code table over {length, symbols}; dot=0, dash=1, first symbol highest.
  function automatic logic [7:0] morse_lut(input logic [2:0] len, input logic [4:0] code);
    logic [7:0] c;
    c = 8'h3F;
    case ({len, code})
      {3'd2, 5'b00001}: c = 8'h41; // A
      {3'd4, 5'b01000}: c = 8'h42; // B
      {3'd4, 5'b01010}: c = 8'h43; // C
      {3'd3, 5'b00100}: c = 8'h44; // D
      {3'd1, 5'b00000}: c = 8'h45; // E
      {3'd4, 5'b00010}: c = 8'h46; // F
      {3'd3, 5'b00110}: c = 8'h47; // G
      {3'd4, 5'b00000}: c = 8'h48; // H
      {3'd2, 5'b00000}: c = 8'h49; // I
      {3'd4, 5'b00111}: c = 8'h4A; // J
      {3'd3, 5'b00101}: c = 8'h4B; // K
      {3'd4, 5'b00100}: c = 8'h4C; // L
      {3'd2, 5'b00011}: c = 8'h4D; // M
      {3'd2, 5'b00010}: c = 8'h4E; // N
      {3'd3, 5'b00111}: c = 8'h4F; // O
      {3'd4, 5'b00110}: c = 8'h50; // P
      {3'd4, 5'b01101}: c = 8'h51; // Q
      {3'd3, 5'b00010}: c = 8'h52; // R
      {3'd3, 5'b00000}: c = 8'h53; // S
      {3'd1, 5'b00001}: c = 8'h54; // T
      {3'd3, 5'b00001}: c = 8'h55; // U
      {3'd4, 5'b00001}: c = 8'h56; // V
      {3'd3, 5'b00011}: c = 8'h57; // W
      {3'd4, 5'b01001}: c = 8'h58; // X
      {3'd4, 5'b01011}: c = 8'h59; // Y
      {3'd4, 5'b01100}: c = 8'h5A; // Z
      {3'd5, 5'b11111}: c = 8'h30; // 0
      {3'd5, 5'b01111}: c = 8'h31; // 1
      {3'd5, 5'b00111}: c = 8'h32; // 2
      {3'd5, 5'b00011}: c = 8'h33; // 3
      {3'd5, 5'b00001}: c = 8'h34; // 4
      {3'd5, 5'b00000}: c = 8'h35; // 5
      {3'd5, 5'b10000}: c = 8'h36; // 6
      {3'd5, 5'b11000}: c = 8'h37; // 7
      {3'd5, 5'b11100}: c = 8'h38; // 8
      {3'd5, 5'b11110}: c = 8'h39; // 9
      default:          c = 8'h3F;
    endcase
    return c;
  endfunction

  assign lut_char = morse_lut(sym_len, sym_buf);
  assign tick     = (div_cnt == DIV_LAST);
  assign SYM_LEN  = sym_len;
  assign BUSY     = (state != IDLE);

  // Two-flop synchronizer plus registered edge detect on the synchronized key.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= 1'b0;
      ks       <= 1'b0;
      ks_d     <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      key_meta <= KEY;
      ks       <= key_meta;
      ks_d     <= ks;
      rise_q   <= ks & ~ks_d;
      fall_q   <= ~ks & ks_d;
    end
  end

  // Tick divider; restarted on every key edge so ticks count whole units since it.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if ((ks != ks_d) || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Decode FSM: press/gap timing, symbol assembly and registered character output.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      press_cnt  <= '0;
      gap_cnt    <= '0;
      sym_buf    <= '0;
      sym_len    <= '0;
      ovf        <= 1'b0;
      pending    <= 1'b0;
      ASCII      <= '0;
      CHAR_VALID <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      CHAR_VALID <= 1'b0;
      ERR        <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            // Press that arrived on the emit cycle; drop it if it already ended.
            pending <= 1'b0;
            if (!fall_q) begin
              state     <= MARK;
              press_cnt <= '0;
            end
          end else if (rise_q) begin
            state     <= MARK;
            press_cnt <= '0;
          end
        end
        MARK: begin
          if (fall_q) begin
            gap_cnt <= '0;
            if (press_cnt == '0) begin
              state <= (sym_len != 3'd0) ? SPACE : IDLE;
            end else begin
              if (sym_len < 3'd5) begin
                sym_buf <= {sym_buf[3:0], (press_cnt >= DASH_CNT)};
                sym_len <= sym_len + 3'd1;
              end else begin
                ovf <= 1'b1;
              end
              state <= SPACE;
            end
          end else if (tick && (press_cnt != CNT_MAX)) begin
            press_cnt <= press_cnt + CNT_W'(1);
          end
        end
        SPACE: begin
          if (gap_cnt >= GAP_CNT) begin
            CHAR_VALID <= 1'b1;
            ASCII      <= ovf ? 8'h3F : lut_char;
            ERR        <= ovf || (lut_char == 8'h3F);
            sym_buf    <= '0;
            sym_len    <= '0;
            ovf        <= 1'b0;
            pending    <= rise_q;
            state      <= IDLE;
          end else if (rise_q) begin
            state     <= MARK;
            press_cnt <= '0;
          end else if (tick && (gap_cnt != CNT_MAX)) begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: expected characters go into a
// scoreboard queue as keying is driven and are popped on each strobe.
module tb_morse_decoder;

  logic       CLOCK;
  logic       reset_n;
  logic       KEY;
  logic [7:0] ASCII;
  logic       CHAR_VALID;
  logic       ERR;
  logic [2:0] SYM_LEN;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];   // {err, ascii}

  morse_decoder #(
    .TICK_DIV(4), .DASH_UNITS(2), .GAP_UNITS(3), .CNT_W(8)
  ) dut (
    .CLOCK(CLOCK), .reset_n(reset_n), .KEY(KEY),
    .ASCII(ASCII), .CHAR_VALID(CHAR_VALID), .ERR(ERR),
    .SYM_LEN(SYM_LEN), .BUSY(BUSY)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // All keying tasks start and end on a falling clock edge.
  task automatic press(input int n);
    KEY = 1'b1;
    repeat (n) @(negedge CLOCK);
    KEY = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // '.' = 4-cycle press (1 tick), '-' = 8-cycle press (2 ticks), 4 low between.
  task automatic send_char(input string code, input logic [7:0] exp_ascii, input logic exp_err);
    exp_q.push_back({exp_err, exp_ascii});
    for (int i = 0; i < code.len(); i++) begin
      press((code[i] == "-") ? 8 : 4);
      gap(4);
    end
    gap(16);
  endtask

  // Scoreboard monitor: sample just after each rising edge.
  always @(posedge CLOCK) begin
    #1;
    if (reset_n && CHAR_VALID) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", {31'd0, CHAR_VALID}, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("ascii", {24'd0, ASCII}, {24'd0, e[7:0]});
        check("err", {31'd0, ERR}, {31'd0, e[8]});
        check("sym_len_clear", {29'd0, SYM_LEN}, 32'd0);
      end
    end else if (ERR) begin
      check("err_unqualified", {31'd0, ERR}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    KEY     = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge CLOCK);
    check("rst_ascii", {24'd0, ASCII}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_symlen", {29'd0, SYM_LEN}, 32'd0);
    check("rst_valid", {31'd0, CHAR_VALID}, 32'd0);
    reset_n = 1'b1;
    gap(4);

    // Single letters and dot/dash boundary (7 cycles = 1 tick, 8 = 2 ticks)
    send_char(".", 8'h45, 1'b0);
    check("ascii_hold", {24'd0, ASCII}, 32'h45);
    send_char("-", 8'h54, 1'b0);
    exp_q.push_back({1'b0, 8'h54});
    press(12); gap(20);
    exp_q.push_back({1'b0, 8'h45});
    press(7); gap(20);

    // Async reset mid-character with key held, then decoding restarts
    press(4); gap(4);
    KEY = 1'b1;
    gap(6);
    check("pre_rst_symlen", {29'd0, SYM_LEN}, 32'd1);
    check("pre_rst_busy", {31'd0, BUSY}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ascii", {24'd0, ASCII}, 32'd0);
    check("midrst_valid", {31'd0, CHAR_VALID}, 32'd0);
    check("midrst_err", {31'd0, ERR}, 32'd0);
    check("midrst_symlen", {29'd0, SYM_LEN}, 32'd0);
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    gap(2);
    reset_n = 1'b1;
    exp_q.push_back({1'b0, 8'h54});
    gap(10);
    KEY = 1'b0;
    gap(20);

    // Multi-symbol letters
    send_char(".-", 8'h41, 1'b0);
    send_char("...", 8'h53, 1'b0);
    send_char("---", 8'h4F, 1'b0);
    send_char("...", 8'h53, 1'b0);

    // Digits, overflow, unmatched
    send_char(".....", 8'h35, 1'b0);
    send_char("-----", 8'h30, 1'b0);
    exp_q.push_back({1'b1, 8'h3F});
    for (int i = 0; i < 6; i++) begin
      press(4); gap(4);
    end
    check("ovf_symlen_cap", {29'd0, SYM_LEN}, 32'd5);
    gap(16);
    send_char("--.--", 8'h3F, 1'b1);

    // Glitches: idle pulse gives nothing; mid-character pulse is ignored
    press(1); gap(20);
    check("glitch_idle_symlen", {29'd0, SYM_LEN}, 32'd0);
    check("glitch_idle_busy", {31'd0, BUSY}, 32'd0);
    exp_q.push_back({1'b0, 8'h49});
    press(4); gap(4);
    press(1); gap(4);
    check("glitch_mid_symlen", {29'd0, SYM_LEN}, 32'd1);
    press(4); gap(20);

    // Gap of GAP_UNITS-1 ticks (11 cycles low) keeps the character going
    exp_q.push_back({1'b0, 8'h41});
    press(4); gap(11); press(8); gap(20);

    // Press landing on the emit cycle (12 cycles low): E emitted, then T decoded
    exp_q.push_back({1'b0, 8'h45});
    exp_q.push_back({1'b0, 8'h54});
    press(4); gap(12); press(8); gap(20);

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge CLOCK);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
